// File: rtl/jtshouse_colmix.sv
// jtshouse_colmix: final colour mixer for the Namco System 1 video path.
// Latency: 2 pxl_cen from input sample to red/green/blue and lhbl_dly/lvbl_dly.
// Backpressure: none; it is a free-running pixel pipeline gated only by pxl_cen.
//
// Ports:
//   rst, clk           asynchronous active-high reset, system clock
//   pxl_cen            one-clk pixel enable, at least 2 clk between pulses
//   lhbl, lvbl         active-low blanking inputs
//   scr_pxl/scr_prio   tilemap palette index and priority
//   obj_pxl/obj_prio   sprite palette index and priority
//   pal_addr/pal_rgb   palette BRAM port (data valid 1 clk after address)
//   red/green/blue     8-bit colour output
//   lhbl_dly/lvbl_dly  blanking delayed to line up with the colour output
//   gfx_en             layer enables, bit0 tilemap, bit1 sprites
//
// Optional build macro JTSHOUSE_COLMIX_GFXEN_EN: when defined, gfx_en can
// hide the sprite layer and/or replace the tilemap by index 0 at priority 0.
// When undefined, gfx_en is ignored and every layer is always enabled.

module jtshouse_colmix #(
  parameter logic [7:0] SHADOW     = 8'hFE,
  parameter logic [3:0] OBJ_TRANSP = 4'hF
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        pxl_cen,
  input  logic        lhbl,
  input  logic        lvbl,
  input  logic [10:0] scr_pxl,
  input  logic [2:0]  scr_prio,
  input  logic [10:0] obj_pxl,
  input  logic [2:0]  obj_prio,
  output logic [10:0] pal_addr,
  input  logic [23:0] pal_rgb,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        lhbl_dly,
  output logic        lvbl_dly,
  input  logic [3:0]  gfx_en
);

  // Layer selection inputs after the optional layer enables are applied.
  logic [10:0] scr_eff;
  logic [2:0]  scr_prio_eff;
  logic        obj_opaque;

  // Stage 1 decision.
  logic        obj_win;
  logic        shd;
  logic [10:0] sel;

  // Flags travelling alongside pal_addr, consumed one pixel later.
  logic        shd_s1;
  logic        lhbl_s1;
  logic        lvbl_s1;

  // Next output colour.
  logic [7:0]  red_nx;
  logic [7:0]  green_nx;
  logic [7:0]  blue_nx;

  // Upper enable bits are reserved; this keeps them from being flagged.
  logic        unused_gfx;
  assign unused_gfx = ^gfx_en;

`ifdef JTSHOUSE_COLMIX_GFXEN_EN
  // A disabled tilemap degenerates to the lowest backdrop so that any
  // opaque sprite (priority >= 0) always wins over it.
  always_comb begin
    scr_eff      = gfx_en[0] ? scr_pxl  : 11'd0;
    scr_prio_eff = gfx_en[0] ? scr_prio : 3'd0;
    obj_opaque   = gfx_en[1] && (obj_pxl[3:0] != OBJ_TRANSP);
  end
`else
  always_comb begin
    scr_eff      = scr_pxl;
    scr_prio_eff = scr_prio;
    obj_opaque   = obj_pxl[3:0] != OBJ_TRANSP;
  end
`endif

  // The tilemap is always opaque, so a shadow sprite simply lets the
  // tilemap colour through and flags it for halving at the output.
  always_comb begin
    obj_win = obj_opaque && (obj_prio >= scr_prio_eff);
    shd     = obj_win && (obj_pxl[7:0] == SHADOW);
    sel     = (obj_win && !shd) ? obj_pxl : scr_eff;
  end

  // Palette data is already settled when the next pxl_cen arrives, so the
  // output stage works directly on pal_rgb with the flags from stage 1.
  always_comb begin
    red_nx   = 8'd0;
    green_nx = 8'd0;
    blue_nx  = 8'd0;
    if (lhbl_s1 && lvbl_s1) begin
      if (shd_s1) begin
        red_nx   = {1'b0, pal_rgb[23:17]};
        green_nx = {1'b0, pal_rgb[15:9]};
        blue_nx  = {1'b0, pal_rgb[7:1]};
      end else begin
        red_nx   = pal_rgb[23:16];
        green_nx = pal_rgb[15:8];
        blue_nx  = pal_rgb[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pal_addr <= 11'd0;
      shd_s1   <= 1'b0;
      lhbl_s1  <= 1'b0;
      lvbl_s1  <= 1'b0;
      red      <= 8'd0;
      green    <= 8'd0;
      blue     <= 8'd0;
      lhbl_dly <= 1'b0;
      lvbl_dly <= 1'b0;
    end else if (pxl_cen) begin
      pal_addr <= sel;
      shd_s1   <= shd;
      lhbl_s1  <= lhbl;
      lvbl_s1  <= lvbl;
      red      <= red_nx;
      green    <= green_nx;
      blue     <= blue_nx;
      lhbl_dly <= lhbl_s1;
      lvbl_dly <= lvbl_s1;
    end
  end

endmodule

// File: tb/tb_jtshouse_colmix.sv
module tb_jtshouse_colmix;

  logic        rst;
  logic        clk;
  logic        pxl_cen;
  logic        lhbl;
  logic        lvbl;
  logic [10:0] scr_pxl;
  logic [2:0]  scr_prio;
  logic [10:0] obj_pxl;
  logic [2:0]  obj_prio;
  logic [10:0] pal_addr;
  logic [23:0] pal_rgb;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        lhbl_dly;
  logic        lvbl_dly;
  logic [3:0]  gfx_en;

  int total = 0;
  int bad   = 0;

  // Expected output word: {red, green, blue, lhbl_dly, lvbl_dly}
  logic [25:0] exp_q[$];
  logic [25:0] last_out;
  logic [10:0] last_addr;

  logic [23:0] mem [0:2047];

  jtshouse_colmix dut (
    .rst      (rst),
    .clk      (clk),
    .pxl_cen  (pxl_cen),
    .lhbl     (lhbl),
    .lvbl     (lvbl),
    .scr_pxl  (scr_pxl),
    .scr_prio (scr_prio),
    .obj_pxl  (obj_pxl),
    .obj_prio (obj_prio),
    .pal_addr (pal_addr),
    .pal_rgb  (pal_rgb),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .lhbl_dly (lhbl_dly),
    .lvbl_dly (lvbl_dly),
    .gfx_en   (gfx_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Palette BRAM model: registered read, one clk of latency.
  always @(posedge clk) pal_rgb <= mem[pal_addr];

  // Drive one pixel, check pal_addr for it, push its expected RGB and
  // compare the RGB of the previous pixel which emerges on this pxl_cen.
  task automatic drive_pixel(input logic [10:0] s, input logic [2:0] sp,
                             input logic [10:0] o, input logic [2:0] op,
                             input logic hb, input logic vb);
    logic        opaque, win, shadow;
    logic [10:0] s_eff, addr;
    logic [2:0]  sp_eff;
    logic [23:0] c;
    logic [23:0] rgb;
    logic [25:0] got, want;
    s_eff  = s;
    sp_eff = sp;
    opaque = (o[3:0] != 4'hF);
`ifdef JTSHOUSE_COLMIX_GFXEN_EN
    if (!gfx_en[1]) opaque = 1'b0;
    if (!gfx_en[0]) begin
      s_eff  = 11'd0;
      sp_eff = 3'd0;
    end
`endif
    win    = opaque && (op >= sp_eff);
    shadow = win && (o[7:0] == 8'hFE);
    addr   = (win && !shadow) ? o : s_eff;
    c      = mem[addr];
    if (!(hb && vb))  rgb = 24'd0;
    else if (shadow)  rgb = {c[23:16] / 8'd2, c[15:8] / 8'd2, c[7:0] / 8'd2};
    else              rgb = c;

    @(posedge clk); #1;
    scr_pxl = s; scr_prio = sp; obj_pxl = o; obj_prio = op;
    lhbl = hb; lvbl = vb; pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;

    total++;
    if (pal_addr !== addr) begin
      bad++;
      $display("FAIL pal_addr: got %h expected %h", pal_addr, addr);
    end
    last_addr = addr;

    exp_q.push_back({rgb, hb, vb});
    if (exp_q.size() == 2) begin
      want = exp_q.pop_front();
      got  = {red, green, blue, lhbl_dly, lvbl_dly};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rgb_blank: got %h expected %h", got, want);
      end
      last_out = want;
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({pal_addr, red, green, blue, lhbl_dly, lvbl_dly} !== 37'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h/%h%h%h/%b%b expected all zero",
               pal_addr, red, green, blue, lhbl_dly, lvbl_dly);
    end
    rst = 1'b0;
    // Cleared stage-1 registers emerge as black with blanks low.
    exp_q.delete();
    exp_q.push_back(26'd0);
    last_out = 26'd0;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_priority();
    // Sprite beats tilemap, then tie, then loss, then transparent sprite.
    drive_pixel(11'h123, 3'd2, 11'h245, 3'd3, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd2, 11'h245, 3'd2, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd2, 11'h245, 3'd1, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd2, 11'h24F, 3'd7, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd7, 11'h245, 3'd7, 1'b1, 1'b1);
    // Explicit value check on the first win pixel colour
    total++;
    if (mem[11'h245] !== 24'h102030 || last_addr !== 11'h245) begin
      bad++;
      $display("FAIL prio_top_win_addr: got %h expected %h", last_addr, 11'h245);
    end
  endtask

  task automatic test_shadow();
    drive_pixel(11'h123, 3'd1, 11'h0FE, 3'd5, 1'b1, 1'b1); // shadowed -> 7F/40/00
    drive_pixel(11'h123, 3'd1, 11'h0FE, 3'd0, 1'b1, 1'b1); // tilemap wins -> FF/81/01
    drive_pixel(11'h123, 3'd1, 11'h5FE, 3'd5, 1'b1, 1'b1); // shadow, other palette
    drive_pixel(11'h245, 3'd0, 11'h0FE, 3'd0, 1'b1, 1'b1); // shadow over 102030
    drive_pixel(11'h300, 3'd0, 11'h000, 3'd0, 1'b1, 1'b1);
    total++;
    if (last_out !== {24'h081018, 2'b11}) begin
      bad++;
      $display("FAIL shadow_value: got %h expected %h", last_out, {24'h081018, 2'b11});
    end
  endtask

  task automatic test_blank();
    for (int i = 0; i < 10; i++)
      drive_pixel(11'h300, 3'd7, 11'h00F, 3'd7, !(i >= 3 && i <= 5), 1'b1);
    drive_pixel(11'h300, 3'd7, 11'h00F, 3'd7, 1'b1, 1'b0);
    drive_pixel(11'h300, 3'd7, 11'h00F, 3'd7, 1'b1, 1'b1);
    drive_pixel(11'h300, 3'd7, 11'h00F, 3'd7, 1'b1, 1'b1);
  endtask

  task automatic test_hold();
    logic [25:0] got;
    repeat (10) @(posedge clk);
    #1;
    got = {red, green, blue, lhbl_dly, lvbl_dly};
    total++;
    if (got !== last_out || pal_addr !== last_addr) begin
      bad++;
      $display("FAIL hold: got %h/%h expected %h/%h", got, pal_addr, last_out, last_addr);
    end
  endtask

  task automatic test_midline_reset();
    drive_pixel(11'h245, 3'd3, 11'h00F, 3'd0, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd3, 11'h00F, 3'd0, 1'b1, 1'b1);
    do_reset();
    drive_pixel(11'h245, 3'd3, 11'h00F, 3'd0, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd3, 11'h00F, 3'd0, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd3, 11'h00F, 3'd0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      drive_pixel(11'($urandom), 3'($urandom), 11'($urandom), 3'($urandom),
                  ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) != 0));
  endtask

  task automatic test_gfx_en();
`ifdef JTSHOUSE_COLMIX_GFXEN_EN
    gfx_en = 4'b0001;
    drive_pixel(11'h123, 3'd0, 11'h245, 3'd7, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd0, 11'h0FE, 3'd7, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd0, 11'h245, 3'd7, 1'b1, 1'b1);
    gfx_en = 4'b0010;
    drive_pixel(11'h123, 3'd7, 11'h245, 3'd0, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd7, 11'h24F, 3'd0, 1'b1, 1'b1);
`else
    gfx_en = 4'b0000;
    drive_pixel(11'h123, 3'd2, 11'h245, 3'd3, 1'b1, 1'b1);
    drive_pixel(11'h123, 3'd2, 11'h245, 3'd1, 1'b1, 1'b1);
`endif
    gfx_en = 4'b1111;
    drive_pixel(11'h123, 3'd2, 11'h245, 3'd3, 1'b1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] a;
      a = i[10:0];
      mem[i] = {a[7:0] ^ 8'h5A, a[10:3], ~a[7:0]};
    end
    mem[11'h245] = 24'h102030;
    mem[11'h123] = 24'hFF8101;
    mem[11'h300] = 24'hC0FFEE;
    mem[11'h000] = 24'h010203;

    rst = 1'b1; pxl_cen = 1'b0; lhbl = 1'b0; lvbl = 1'b0;
    scr_pxl = 11'd0; scr_prio = 3'd0; obj_pxl = 11'd0; obj_prio = 3'd0;
    gfx_en = 4'b1111;
    last_out = 26'd0; last_addr = 11'd0;

    test_reset();
    test_priority();
    test_shadow();
    test_blank();
    test_hold();
    test_midline_reset();
    test_hold();
    test_random();
    test_gfx_en();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
